bp_be_fp_result_collector: RTL

- Back end of the pipelined FP unit: tracks every op issued into the fixed-latency FPU and captures its result and exception flags when they emerge.
- NaN-boxes single-precision FP results and buffers them in a small FIFO for a stallable writeback port.
- Accumulates sticky fflags for the FCSR.
- Throttles FPU issue with credits so that no result is ever dropped.

---
 rtl/bp_be_fp_result_collector.sv | 134 +++++++++++++
 1 files changed

// File: rtl/bp_be_fp_result_collector.sv
// FP back end: tags ops through the fixed-latency FPU, captures and NaN-boxes
// results into a credit-protected writeback FIFO, and accumulates sticky fflags.
module bp_be_fp_result_collector #(
  parameter int latency_p        = 4,
  parameter int dword_width_p    = 64,
  parameter int reg_addr_width_p = 5,
  parameter int fifo_els_p       = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        issue_v_i,
  output logic                        issue_ready_o,
  input  logic [reg_addr_width_p-1:0] issue_rd_i,
  input  logic                        issue_fp_dest_i,
  input  logic                        issue_double_i,
  input  logic                        flush_i,
  input  logic [dword_width_p-1:0]    fpu_result_i,
  input  logic [4:0]                  fpu_eflags_i,
  output logic                        wb_v_o,
  input  logic                        wb_yumi_i,
  output logic [reg_addr_width_p-1:0] wb_rd_o,
  output logic                        wb_fp_dest_o,
  output logic [dword_width_p-1:0]    wb_data_o,
  output logic [4:0]                  fflags_o,
  input  logic                        fflags_clear_i,
  output logic                        busy_o
);

  localparam int stages_lp = latency_p - 1;
  localparam int cnt_w_lp  = $clog2(fifo_els_p + 1);
  localparam int ptr_w_lp  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam logic [cnt_w_lp:0]   credits_lp = (cnt_w_lp + 1)'(fifo_els_p);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(fifo_els_p - 1);

  function automatic logic [dword_width_p-1:0] nan_box(
    input logic fp_dest, input logic dbl, input logic [dword_width_p-1:0] res);
    if (fp_dest && !dbl)
      return {{(dword_width_p-32){1'b1}}, res[31:0]};
    return res;
  endfunction

  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  logic [stages_lp-1:0]        tag_vld_p;
  logic [reg_addr_width_p-1:0] tag_rd_p  [stages_lp];
  logic                        tag_fp_p  [stages_lp];
  logic                        tag_dbl_p [stages_lp];

  logic [reg_addr_width_p-1:0] fifo_rd_mem   [fifo_els_p];
  logic                        fifo_fp_mem   [fifo_els_p];
  logic [dword_width_p-1:0]    fifo_data_mem [fifo_els_p];

  logic                  init_r;
  logic [cnt_w_lp-1:0]   inflight_cnt, fifo_cnt;
  logic [ptr_w_lp-1:0]   wptr, rptr;
  logic                  issue_fire, cap_v, capture, deq;
  logic [cnt_w_lp:0]     used_credits;

  assign used_credits  = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
  assign issue_ready_o = init_r && (used_credits < credits_lp);
  assign issue_fire    = issue_v_i && issue_ready_o;
  assign cap_v         = tag_vld_p[stages_lp-1];
  assign capture       = cap_v && !flush_i;
  assign wb_v_o        = (fifo_cnt != '0);
  assign deq           = wb_yumi_i && wb_v_o;
  assign wb_rd_o       = fifo_rd_mem[rptr];
  assign wb_fp_dest_o  = fifo_fp_mem[rptr];
  assign wb_data_o     = fifo_data_mem[rptr];
  assign busy_o        = (|tag_vld_p) || wb_v_o;

  // Issue -> tag pipe -> FIFO storage (data path, no reset)
  always_ff @(posedge clk_i) begin
    tag_rd_p[0]  <= issue_rd_i;
    tag_fp_p[0]  <= issue_fp_dest_i;
    tag_dbl_p[0] <= issue_double_i;
    for (int i = 1; i < stages_lp; i++) begin
      tag_rd_p[i]  <= tag_rd_p[i-1];
      tag_fp_p[i]  <= tag_fp_p[i-1];
      tag_dbl_p[i] <= tag_dbl_p[i-1];
    end
    if (capture) begin
      fifo_rd_mem[wptr]   <= tag_rd_p[stages_lp-1];
      fifo_fp_mem[wptr]   <= tag_fp_p[stages_lp-1];
      fifo_data_mem[wptr] <= nan_box(tag_fp_p[stages_lp-1], tag_dbl_p[stages_lp-1], fpu_result_i);
    end
  end

  // Control: valids, credits, pointers and sticky flags
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      init_r       <= 1'b0;
      tag_vld_p    <= '0;
      inflight_cnt <= '0;
      fifo_cnt     <= '0;
      wptr         <= '0;
      rptr         <= '0;
      fflags_o     <= '0;
    end else begin
      init_r <= 1'b1;
      if (flush_i) begin
        tag_vld_p    <= '0;
        inflight_cnt <= '0;
        fifo_cnt     <= '0;
        wptr         <= '0;
        rptr         <= '0;
      end else begin
        tag_vld_p[0] <= issue_fire;
        for (int i = 1; i < stages_lp; i++) tag_vld_p[i] <= tag_vld_p[i-1];
        case ({issue_fire, cap_v})
          2'b10:   inflight_cnt <= inflight_cnt + cnt_w_lp'(1);
          2'b01:   inflight_cnt <= inflight_cnt - cnt_w_lp'(1);
          default: inflight_cnt <= inflight_cnt;
        endcase
        case ({capture, deq})
          2'b10:   fifo_cnt <= fifo_cnt + cnt_w_lp'(1);
          2'b01:   fifo_cnt <= fifo_cnt - cnt_w_lp'(1);
          default: fifo_cnt <= fifo_cnt;
        endcase
        if (capture) wptr <= next_ptr(wptr);
        if (deq)     rptr <= next_ptr(rptr);
      end
      // A flushed capture never reaches the flags
      case ({fflags_clear_i, capture})
        2'b10:   fflags_o <= '0;
        2'b11:   fflags_o <= fpu_eflags_i;
        2'b01:   fflags_o <= fflags_o | fpu_eflags_i;
        default: fflags_o <= fflags_o;
      endcase
    end
  end

endmodule
